// File: rtl/clk_cross_pkg.sv
// Shared definitions for the frame link: widths, frame field positions and
// the receiver FSM state encoding.
package clk_cross_pkg;
  localparam int WORD_W  = 9;
  localparam int FRAME_W = 20;
  localparam int ADDR_W  = 2;
  localparam int SEQ_W   = 2;

  localparam int SEQ_HI = 19;
  localparam int SEQ_LO = 18;
  localparam int WA_HI  = 17;
  localparam int WA_LO  = 9;
  localparam int WB_HI  = 8;
  localparam int WB_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR_A = 2'd1,
    ST_WR_B = 2'd2
  } state_e;

  // Port-A address is {bank, word}; bank comes from the low bit of the tag.
  function automatic logic [ADDR_W-1:0] wr_addr(input logic bank, input logic word);
    return {bank, word};
  endfunction
endpackage

// File: rtl/frame_skid_reg.sv
// One-deep frame holding register with a full flag. A load in the same cycle
// as an unload keeps the register full with the new frame.
module frame_skid_reg
  import clk_cross_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_unload,
  input  logic [FRAME_W-1:0] i_din,
  output logic [FRAME_W-1:0] o_dout,
  output logic               o_full
);
  logic [FRAME_W-1:0] r_data;
  logic               r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_load)
        r_data <= i_din;
      if (i_load)
        r_full <= 1'b1;
      else if (i_unload)
        r_full <= 1'b0;
    end
  end

  assign o_dout = r_data;
  assign o_full = r_full;
endmodule

// File: rtl/clk_cross_receive.sv
// Frame receiver: unpacks each 20-bit frame into two BRAM port-A writes,
// checks the sequence tag and holds one frame in a skid register while busy.
module clk_cross_receive
  import clk_cross_pkg::*;
(
  input  logic               clk_6144mhz,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] data_in,
  input  logic               data_in_valid,
  input  logic               err_clear,
  output logic               bram_wea,
  output logic [ADDR_W-1:0]  bram_addra,
  output logic [WORD_W-1:0]  bram_dina,
  output logic               frame_done,
  output logic               done_bank,
  output logic               busy,
  output logic               seq_err,
  output logic               overflow
);
  state_e             r_state, w_nstate;
  logic [FRAME_W-1:0] r_wrk, w_wrk_din;
  logic               w_wrk_load;
  logic               w_skd_load, w_skd_unload, w_skd_full;
  logic [FRAME_W-1:0] w_skd_dout;
  logic [SEQ_W-1:0]   r_exp_seq, w_tag;
  logic               w_drop, w_seq_mis;
  logic               r_seq_err, r_overflow, r_frame_done, r_done_bank;

  frame_skid_reg u_skd (
    .clk      (clk_6144mhz),
    .rst_n    (rst_n),
    .i_load   (w_skd_load),
    .i_unload (w_skd_unload),
    .i_din    (data_in),
    .o_dout   (w_skd_dout),
    .o_full   (w_skd_full)
  );

  always_ff @(posedge clk_6144mhz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  // Every load into wrk re-enters WR_A; the skid is drained before new input.
  always_comb begin
    w_nstate     = r_state;
    w_wrk_load   = 1'b0;
    w_wrk_din    = data_in;
    w_skd_load   = 1'b0;
    w_skd_unload = 1'b0;
    w_drop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (data_in_valid) begin
          w_wrk_load = 1'b1;
          w_nstate   = ST_WR_A;
        end
      end
      ST_WR_A: begin
        w_nstate = ST_WR_B;
        if (data_in_valid) begin
          if (w_skd_full) w_drop     = 1'b1;
          else            w_skd_load = 1'b1;
        end
      end
      ST_WR_B: begin
        if (w_skd_full) begin
          w_wrk_load   = 1'b1;
          w_wrk_din    = w_skd_dout;
          w_skd_unload = 1'b1;
          w_skd_load   = data_in_valid;
          w_nstate     = ST_WR_A;
        end else if (data_in_valid) begin
          w_wrk_load = 1'b1;
          w_nstate   = ST_WR_A;
        end else begin
          w_nstate = ST_IDLE;
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    bram_wea   = 1'b0;
    bram_addra = '0;
    bram_dina  = '0;
    unique case (r_state)
      ST_WR_A: begin
        bram_wea   = 1'b1;
        bram_addra = wr_addr(r_wrk[SEQ_LO], 1'b0);
        bram_dina  = r_wrk[WA_HI:WA_LO];
      end
      ST_WR_B: begin
        bram_wea   = 1'b1;
        bram_addra = wr_addr(r_wrk[SEQ_LO], 1'b1);
        bram_dina  = r_wrk[WB_HI:WB_LO];
      end
      default: ;
    endcase
  end

  assign w_tag     = w_wrk_din[SEQ_HI:SEQ_LO];
  assign w_seq_mis = w_wrk_load && (w_tag != r_exp_seq);

  // On a match tag+1 equals exp_seq+1, so one update covers both match and resync.
  always_ff @(posedge clk_6144mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_wrk        <= '0;
      r_exp_seq    <= '0;
      r_seq_err    <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_done_bank  <= 1'b0;
    end else begin
      if (w_wrk_load) begin
        r_wrk     <= w_wrk_din;
        r_exp_seq <= w_tag + 2'd1;
      end
      if (w_seq_mis)      r_seq_err <= 1'b1;
      else if (err_clear) r_seq_err <= 1'b0;
      if (w_drop)         r_overflow <= 1'b1;
      else if (err_clear) r_overflow <= 1'b0;
      r_frame_done <= (r_state == ST_WR_B);
      r_done_bank  <= (r_state == ST_WR_B) && r_wrk[SEQ_LO];
    end
  end

  assign frame_done = r_frame_done;
  assign done_bank  = r_done_bank;
  assign busy       = (r_state != ST_IDLE);
  assign seq_err    = r_seq_err;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_clk_cross_receive.sv
// Directed bench: a cycle table of inputs and hand-computed outputs, plus
// hand-written reset sequences.
module tb_clk_cross_receive;
  import clk_cross_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [FRAME_W-1:0] data_in;
  logic               data_in_valid;
  logic               err_clear;
  logic               bram_wea;
  logic [ADDR_W-1:0]  bram_addra;
  logic [WORD_W-1:0]  bram_dina;
  logic               frame_done, done_bank, busy, seq_err, overflow;

  int n_chk = 0;
  int n_err = 0;

  clk_cross_receive dut (
    .clk_6144mhz   (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .err_clear     (err_clear),
    .bram_wea      (bram_wea),
    .bram_addra    (bram_addra),
    .bram_dina     (bram_dina),
    .frame_done    (frame_done),
    .done_bank     (done_bank),
    .busy          (busy),
    .seq_err       (seq_err),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [19:0] d;
    logic        clr;
    logic        we;
    logic [1:0]  a;
    logic [8:0]  di;
    logic        fd;
    logic        db;
    logic        se;
    logic        ov;
  } row_t;

  row_t tbl [35];

  function automatic logic [19:0] fr(input logic [1:0] s, input logic [8:0] wa, input logic [8:0] wb);
    return {s, wa, wb};
  endfunction

  function automatic row_t rw(input logic v, input logic [19:0] d, input logic clr,
                              input logic we, input logic [1:0] a, input logic [8:0] di,
                              input logic fd, input logic db, input logic se, input logic ov);
    row_t r;
    r.v = v; r.d = d; r.clr = clr; r.we = we; r.a = a; r.di = di;
    r.fd = fd; r.db = db; r.se = se; r.ov = ov;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_row(input int i, input row_t r);
    chk("wea",   i, 32'(bram_wea),   32'(r.we));
    chk("busy",  i, 32'(busy),       32'(r.we));
    chk("addra", i, 32'(bram_addra), 32'(r.a));
    chk("dina",  i, 32'(bram_dina),  32'(r.di));
    chk("fdone", i, 32'(frame_done), 32'(r.fd));
    chk("dbank", i, 32'(done_bank),  32'(r.db));
    chk("seqer", i, 32'(seq_err),    32'(r.se));
    chk("ovfl",  i, 32'(overflow),   32'(r.ov));
  endtask

  initial begin
    // Row i: outputs expected during cycle i, inputs sampled at the edge ending it.
    tbl[0]  = rw(1, 20'h00203,              0, 0, 0, 0,     0, 0, 0, 0);
    tbl[1]  = rw(0, 0,                      0, 1, 0, 'h001, 0, 0, 0, 0);
    tbl[2]  = rw(0, 0,                      0, 1, 1, 'h003, 0, 0, 0, 0);
    tbl[3]  = rw(0, 0,                      0, 0, 0, 0,     1, 0, 0, 0);
    // alternate-cycle frames, tags 1,2,3,0 across the wrap
    tbl[4]  = rw(1, fr(1, 'h011, 'h022),    0, 0, 0, 0,     0, 0, 0, 0);
    tbl[5]  = rw(0, 0,                      0, 1, 2, 'h011, 0, 0, 0, 0);
    tbl[6]  = rw(1, fr(2, 'h033, 'h044),    0, 1, 3, 'h022, 0, 0, 0, 0);
    tbl[7]  = rw(0, 0,                      0, 1, 0, 'h033, 1, 1, 0, 0);
    tbl[8]  = rw(1, fr(3, 'h055, 'h066),    0, 1, 1, 'h044, 0, 0, 0, 0);
    tbl[9]  = rw(0, 0,                      0, 1, 2, 'h055, 1, 0, 0, 0);
    tbl[10] = rw(1, fr(0, 'h077, 'h088),    0, 1, 3, 'h066, 0, 0, 0, 0);
    tbl[11] = rw(0, 0,                      0, 1, 0, 'h077, 1, 1, 0, 0);
    tbl[12] = rw(0, 0,                      0, 1, 1, 'h088, 0, 0, 0, 0);
    tbl[13] = rw(0, 0,                      0, 0, 0, 0,     1, 0, 0, 0);
    tbl[14] = rw(0, 0,                      0, 0, 0, 0,     0, 0, 0, 0);
    // consecutive-cycle run: 2nd and 3rd pass through skid, 4th hits a full skid in WR_A
    tbl[15] = rw(1, fr(1, 'h101, 'h102),    0, 0, 0, 0,     0, 0, 0, 0);
    tbl[16] = rw(1, fr(2, 'h103, 'h104),    0, 1, 2, 'h101, 0, 0, 0, 0);
    tbl[17] = rw(1, fr(3, 'h105, 'h106),    0, 1, 3, 'h102, 0, 0, 0, 0);
    tbl[18] = rw(1, fr(0, 'h107, 'h108),    0, 1, 0, 'h103, 1, 1, 0, 0);
    tbl[19] = rw(0, 0,                      0, 1, 1, 'h104, 0, 0, 0, 1);
    tbl[20] = rw(0, 0,                      0, 1, 2, 'h105, 1, 0, 0, 1);
    tbl[21] = rw(0, 0,                      0, 1, 3, 'h106, 0, 0, 0, 1);
    tbl[22] = rw(0, 0,                      1, 0, 0, 0,     1, 1, 0, 1);
    // exp_seq is 0: tag 2 mismatches, tag 3 then matches
    tbl[23] = rw(1, fr(2, 'h1AA, 'h155),    0, 0, 0, 0,     0, 0, 0, 0);
    tbl[24] = rw(0, 0,                      0, 1, 0, 'h1AA, 0, 0, 1, 0);
    tbl[25] = rw(1, fr(3, 'h0AB, 'h0CD),    0, 1, 1, 'h155, 0, 0, 1, 0);
    tbl[26] = rw(0, 0,                      1, 1, 2, 'h0AB, 1, 0, 1, 0);
    tbl[27] = rw(0, 0,                      0, 1, 3, 'h0CD, 0, 0, 0, 0);
    tbl[28] = rw(0, 0,                      0, 0, 0, 0,     1, 1, 0, 0);
    // mismatch coinciding with err_clear: the set wins
    tbl[29] = rw(1, fr(1, 'h0F0, 'h00F),    1, 0, 0, 0,     0, 0, 0, 0);
    tbl[30] = rw(0, 0,                      0, 1, 2, 'h0F0, 0, 0, 1, 0);
    tbl[31] = rw(0, 0,                      0, 1, 3, 'h00F, 0, 0, 1, 0);
    tbl[32] = rw(0, 0,                      0, 0, 0, 0,     1, 1, 1, 0);
    tbl[33] = rw(0, 0,                      1, 0, 0, 0,     0, 0, 1, 0);
    tbl[34] = rw(0, 0,                      0, 0, 0, 0,     0, 0, 0, 0);

    rst_n = 1'b0; data_in = '0; data_in_valid = 1'b0; err_clear = 1'b0;

    // reset held with valid toggling: everything stays 0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_row(100 + i, rw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      data_in_valid = ~data_in_valid;
      data_in       = fr(2'(i), 9'h1FF, 9'h1FF);
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_row(110 + i, rw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      chk_row(i, tbl[i]);
      data_in_valid = tbl[i].v;
      data_in       = tbl[i].d;
      err_clear     = tbl[i].clr;
    end

    // reset asserted during WR_A (exp_seq is 2 here, so tag 2 is in order)
    @(negedge clk);
    data_in_valid = 1'b1;
    data_in       = fr(2, 'h111, 'h122);
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("wa_wea", 200, 32'(bram_wea), 32'd1);
    chk("wa_adr", 200, 32'(bram_addra), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wea", 201, 32'(bram_wea), 32'd0);
    chk("rst_dina", 201, 32'(bram_dina), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_fd", 202 + i, 32'(frame_done), 32'd0);
      chk("rst_wea", 202 + i, 32'(bram_wea), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b1;
    data_in       = fr(0, 'h1F1, 'h1F2);
    @(negedge clk);
    data_in_valid = 1'b0;
    chk_row(210, rw(0, 0, 0, 1, 0, 'h1F1, 0, 0, 0, 0));
    @(negedge clk);
    chk_row(211, rw(0, 0, 0, 1, 1, 'h1F2, 0, 0, 0, 0));
    @(negedge clk);
    chk_row(212, rw(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    chk_row(213, rw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
